// File: rtl/pit_timer_n.sv
// Programmable interval timer: NCH independent WIDTH-bit down counters with per-channel gate,
// shared tick enable, sticky terminal-count flags and a maskable, registered interrupt.
`timescale 1ns/1ps
module pit_timer_n #(
  parameter  int NCH   = 3,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(NCH) + 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cs,
  input  logic             rd,
  input  logic             wr,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] idata,
  output logic [WIDTH-1:0] odata,
  input  logic             tick,
  input  logic [NCH-1:0]   gate,
  output logic [NCH-1:0]   out,
  output logic             irq
);

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_RELOAD = 2'd1,
    REG_COUNT  = 2'd2,
    REG_LATCH  = 2'd3
  } reg_e;

  localparam logic [2:0] MODE_TC     = 3'd0;
  localparam logic [2:0] MODE_RATE   = 3'd2;
  localparam logic [2:0] MODE_SQUARE = 3'd3;
  localparam logic [2:0] MODE_STROBE = 3'd4;

  logic [2:0]       mode    [NCH];
  logic [WIDTH-1:0] counter [NCH];
  logic [WIDTH-1:0] reload  [NCH];
  logic [WIDTH-1:0] snap    [NCH];
  logic [NCH-1:0]   en, ie, armed, pending, latched, tc, fired, gate_d;

  logic [AW-1:0] ch_sel;
  reg_e          reg_sel;
  logic          wr_go, rd_go;

  assign ch_sel  = addr >> 2;
  assign reg_sel = reg_e'(addr[1:0]);
  assign wr_go   = cs & wr;
  assign rd_go   = cs & rd & ~wr;

  // N is carried one bit wider so that R==0 can stand for 2^WIDTH.
  logic [WIDTH:0]   n_full [NCH];
  logic [WIDTH-1:0] n_load [NCH];
  logic [WIDTH-1:0] n_hi   [NCH];
  logic [WIDTH-1:0] n_lo   [NCH];
  logic [NCH-1:0]   periodic, step, gate_rise;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      periodic[i] = (mode[i] == MODE_RATE) || (mode[i] == MODE_SQUARE);
      n_full[i]   = (reload[i] == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, reload[i]};
      if (periodic[i] && (n_full[i] < (WIDTH+1)'(2))) n_full[i] = (WIDTH+1)'(2);
      n_load[i]    = n_full[i][WIDTH-1:0];
      n_hi[i]      = WIDTH'((n_full[i] + (WIDTH+1)'(1)) >> 1);
      n_lo[i]      = WIDTH'(n_full[i] >> 1);
      step[i]      = tick & en[i] & gate[i] & armed[i];
      gate_rise[i] = gate[i] & ~gate_d[i] & armed[i] & periodic[i];
    end
  end

  logic [WIDTH-1:0] rd_value;

  always_comb begin
    rd_value = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel == AW'(i)) begin
        case (reg_sel)
          REG_CTRL:   rd_value[7:0] = {tc[i], latched[i], out[i], ie[i], en[i], mode[i]};
          REG_RELOAD: rd_value      = reload[i];
          REG_COUNT:  rd_value      = counter[i];
          REG_LATCH:  rd_value      = snap[i];
          default:    rd_value      = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the per-channel arrays are reset too, since a reset mid-count must leave no stale state.
      for (int i = 0; i < NCH; i++) begin
        mode[i]    <= '0;
        counter[i] <= '0;
        reload[i]  <= '0;
        snap[i]    <= '0;
      end
      en      <= '0;
      ie      <= '0;
      armed   <= '0;
      pending <= '0;
      latched <= '0;
      tc      <= '0;
      fired   <= '0;
      gate_d  <= '0;
      out     <= '1;
      odata   <= '0;
      irq     <= 1'b0;
    end else begin
      odata  <= rd_go ? rd_value : '0;
      irq    <= |(tc & ie);
      gate_d <= gate;
      for (int i = 0; i < NCH; i++) begin
        if (wr_go && (ch_sel == AW'(i)) && (reg_sel == REG_CTRL)) begin
          mode[i]    <= idata[2:0];
          en[i]      <= idata[3];
          ie[i]      <= idata[4];
          armed[i]   <= 1'b0;
          pending[i] <= 1'b0;
          tc[i]      <= 1'b0;
          latched[i] <= 1'b0;
          fired[i]   <= 1'b0;
          out[i]     <= (idata[2:0] != MODE_TC);
        end else begin
          if (pending[i] || gate_rise[i]) begin
            armed[i]   <= 1'b1;
            pending[i] <= 1'b0;
            fired[i]   <= 1'b0;
            out[i]     <= (mode[i] != MODE_TC);
            if (mode[i] == MODE_SQUARE)
              counter[i] <= n_hi[i];
            else if ((mode[i] == MODE_TC) || (mode[i] == MODE_RATE) || (mode[i] == MODE_STROBE))
              counter[i] <= n_load[i];
          end else if (step[i]) begin
            case (mode[i])
              MODE_TC: begin
                counter[i] <= counter[i] - 1'b1;
                if (counter[i] == WIDTH'(1)) begin
                  out[i] <= 1'b1;
                  tc[i]  <= 1'b1;
                end
              end
              MODE_RATE: begin
                if (counter[i] == WIDTH'(1)) begin
                  counter[i] <= n_load[i];
                  out[i]     <= 1'b1;
                  tc[i]      <= 1'b1;
                end else begin
                  counter[i] <= counter[i] - 1'b1;
                  if (counter[i] == WIDTH'(2)) out[i] <= 1'b0;
                end
              end
              MODE_SQUARE: begin
                if (counter[i] == WIDTH'(1)) begin
                  out[i]     <= ~out[i];
                  counter[i] <= out[i] ? n_lo[i] : n_hi[i];
                  if (out[i]) tc[i] <= 1'b1;
                end else begin
                  counter[i] <= counter[i] - 1'b1;
                end
              end
              MODE_STROBE: begin
                counter[i] <= counter[i] - 1'b1;
                if ((counter[i] == WIDTH'(1)) && !fired[i]) begin
                  out[i]   <= 1'b0;
                  fired[i] <= 1'b1;
                  tc[i]    <= 1'b1;
                end else begin
                  out[i] <= 1'b1;
                end
              end
              default: out[i] <= 1'b1;
            endcase
          end else if ((mode[i] != MODE_TC) && !(periodic[i] && gate[i])) begin
            // Strobe pulse ends, reserved modes idle high, and a low gate forces periodic modes high.
            out[i] <= 1'b1;
          end

          if (wr_go && (ch_sel == AW'(i)) && (reg_sel == REG_RELOAD)) begin
            reload[i]  <= idata;
            pending[i] <= 1'b1;
          end
          if (wr_go && (ch_sel == AW'(i)) && (reg_sel == REG_LATCH) && !latched[i]) begin
            snap[i]    <= counter[i];
            latched[i] <= 1'b1;
          end
          if (rd_go && (ch_sel == AW'(i)) && (reg_sel == REG_LATCH)) latched[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pit_timer_n.sv
// Directed bench for pit_timer_n: a 3x16 instance for most features and a 2x8 instance
// for full-period square wave and strobe wrap behaviour.
`timescale 1ns/1ps
module tb_pit_timer_n;

  localparam int NCH   = 3;
  localparam int WIDTH = 16;
  localparam int AW    = $clog2(NCH) + 2;

  localparam logic [1:0] R_CTRL = 2'd0, R_RELOAD = 2'd1, R_COUNT = 2'd2, R_LATCH = 2'd3;

  logic             clk = 1'b0;
  logic             reset_n, cs, rd, wr, tick;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] idata, odata;
  logic [NCH-1:0]   gate, out;
  logic             irq;

  logic             cs8;
  logic [2:0]       addr8;
  logic [7:0]       idata8, odata8;
  logic [1:0]       gate8, out8;
  logic             irq8;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pit_timer_n #(.NCH(NCH), .WIDTH(WIDTH)) u_dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .idata(idata), .odata(odata), .tick(tick), .gate(gate), .out(out), .irq(irq)
  );

  pit_timer_n #(.NCH(2), .WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .cs(cs8), .rd(rd), .wr(wr), .addr(addr8),
    .idata(idata8), .odata(odata8), .tick(tick), .gate(gate8), .out(out8), .irq(irq8)
  );

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int ch, input logic [1:0] r, input logic [WIDTH-1:0] d);
    cs = 1'b1; wr = 1'b1; addr = AW'(ch * 4 + int'(r)); idata = d;
    tk();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input int ch, input logic [1:0] r, output logic [WIDTH-1:0] d);
    cs = 1'b1; rd = 1'b1; addr = AW'(ch * 4 + int'(r));
    tk();
    cs = 1'b0; rd = 1'b0;
    d = odata;
  endtask

  task automatic bus_write8(input int ch, input logic [1:0] r, input logic [7:0] d);
    cs8 = 1'b1; wr = 1'b1; addr8 = 3'(ch * 4 + int'(r)); idata8 = d;
    tk();
    cs8 = 1'b0; wr = 1'b0;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] d;
    reset_n = 1'b0;
    tk(); tk();
    total_cnt++; if (out !== 3'b111) $display("FAIL reset_out: got %b want 111", out); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else pass_cnt++;
    total_cnt++; if (odata !== 16'h0) $display("FAIL reset_odata: got %h want 0000", odata); else pass_cnt++;
    reset_n = 1'b1;
    bus_read(0, R_CTRL, d);
    total_cnt++; if (d !== 16'h0020) $display("FAIL reset_ctrl0: got %h want 0020", d); else pass_cnt++;
    bus_read(2, R_COUNT, d);
    total_cnt++; if (d !== 16'h0000) $display("FAIL reset_count2: got %h want 0000", d); else pass_cnt++;
  endtask

  task automatic test_mode0();
    logic [WIDTH-1:0] d;
    bus_write(0, R_CTRL, 16'h0018);
    bus_write(0, R_RELOAD, 16'd5);
    tick = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tk();
      total_cnt++; if (out[0] !== 1'b0) $display("FAIL m0_low k=%0d: got %b want 0", k, out[0]); else pass_cnt++;
    end
    tk();
    total_cnt++; if (out[0] !== 1'b1) $display("FAIL m0_rise: got %b want 1", out[0]); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL m0_irq_lag: got %b want 0", irq); else pass_cnt++;
    tk();
    total_cnt++; if (irq !== 1'b1) $display("FAIL m0_irq: got %b want 1", irq); else pass_cnt++;
    tick = 1'b0;
    bus_read(0, R_CTRL, d);
    total_cnt++; if (d !== 16'h00B8) $display("FAIL m0_ctrl: got %h want 00b8", d); else pass_cnt++;
    bus_read(0, R_COUNT, d);
    total_cnt++; if (d !== 16'hFFFF) $display("FAIL m0_wrap: got %h want ffff", d); else pass_cnt++;
    bus_write(0, R_CTRL, 16'h0000);
    bus_read(0, R_CTRL, d);
    total_cnt++; if (irq !== 1'b0) $display("FAIL m0_irq_clear: got %b want 0", irq); else pass_cnt++;
    total_cnt++; if (d !== 16'h0000) $display("FAIL m0_tc_clear: got %h want 0000", d); else pass_cnt++;
  endtask

  task automatic test_rate();
    logic [WIDTH-1:0] d;
    logic             exp_out [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int               exp_cnt [9] = '{4, 3, 2, 1, 4, 3, 2, 1, 4};
    bus_write(1, R_CTRL, 16'h000A);
    bus_write(1, R_RELOAD, 16'd4);
    cs = 1'b1; rd = 1'b1; addr = AW'(1 * 4 + int'(R_COUNT));
    tick = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tk();
      total_cnt++; if (out[1] !== exp_out[k]) $display("FAIL rate_out k=%0d: got %b want %b", k, out[1], exp_out[k]); else pass_cnt++;
      if (k > 0) begin
        total_cnt++;
        if (odata !== WIDTH'(exp_cnt[k-1])) $display("FAIL rate_cnt k=%0d: got %0d want %0d", k - 1, odata, exp_cnt[k-1]);
        else pass_cnt++;
      end
    end
    cs = 1'b0; rd = 1'b0; tick = 1'b0;
    bus_read(1, R_CTRL, d);
    total_cnt++; if (d !== 16'h00AA) $display("FAIL rate_ctrl: got %h want 00aa", d); else pass_cnt++;
  endtask

  task automatic test_gate();
    logic [WIDTH-1:0] d;
    tick = 1'b1;
    tk(); tk(); tk();
    total_cnt++; if (out[1] !== 1'b0) $display("FAIL gate_pre: got %b want 0", out[1]); else pass_cnt++;
    gate = 3'b101;
    tk();
    total_cnt++; if (out[1] !== 1'b1) $display("FAIL gate_low1: got %b want 1", out[1]); else pass_cnt++;
    bus_read(1, R_COUNT, d);
    total_cnt++; if (d !== 16'd1) $display("FAIL gate_hold: got %0d want 1", d); else pass_cnt++;
    total_cnt++; if (out[1] !== 1'b1) $display("FAIL gate_low2: got %b want 1", out[1]); else pass_cnt++;
    tk();
    total_cnt++; if (out[1] !== 1'b1) $display("FAIL gate_low3: got %b want 1", out[1]); else pass_cnt++;
    gate = 3'b111;
    tk();
    total_cnt++; if (out[1] !== 1'b1) $display("FAIL gate_edge_out: got %b want 1", out[1]); else pass_cnt++;
    bus_read(1, R_COUNT, d);
    total_cnt++; if (d !== 16'd4) $display("FAIL gate_reload: got %0d want 4", d); else pass_cnt++;
    tick = 1'b0;
    bus_write(1, R_CTRL, 16'h0000);
  endtask

  task automatic test_square();
    logic exp_out [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bus_write(2, R_CTRL, 16'h000B);
    bus_write(2, R_RELOAD, 16'd5);
    tick = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tk();
      total_cnt++; if (out[2] !== exp_out[k]) $display("FAIL sq5 k=%0d: got %b want %b", k, out[2], exp_out[k]); else pass_cnt++;
    end
    tick = 1'b0;
    bus_write(2, R_CTRL, 16'h0000);
  endtask

  task automatic test_square_full();
    int   highs = 0, fall = -1, rise = -1;
    logic prev  = 1'b1;
    bus_write8(0, R_CTRL, 8'h0B);
    bus_write8(0, R_RELOAD, 8'h00);
    tick = 1'b1;
    for (int k = 0; k < 512; k++) begin
      tk();
      if (out8[0] === 1'b1) highs++;
      if (prev === 1'b1 && out8[0] === 1'b0 && fall < 0) fall = k;
      if (prev === 1'b0 && out8[0] === 1'b1 && rise < 0) rise = k;
      prev = out8[0];
    end
    tick = 1'b0;
    total_cnt++; if (highs != 256) $display("FAIL sq256_duty: got %0d high want 256", highs); else pass_cnt++;
    total_cnt++; if (fall != 128) $display("FAIL sq256_fall: got %0d want 128", fall); else pass_cnt++;
    total_cnt++; if (rise != 256) $display("FAIL sq256_rise: got %0d want 256", rise); else pass_cnt++;
  endtask

  task automatic test_strobe();
    int lows = 0, first = -1;
    bus_write8(1, R_CTRL, 8'h0C);
    bus_write8(1, R_RELOAD, 8'd3);
    tk();
    for (int k = 1; k <= 600; k++) begin
      tick = (k % 2 == 1);
      tk();
      if (out8[1] === 1'b0) begin
        lows++;
        if (first < 0) first = k;
      end
    end
    tick = 1'b0;
    total_cnt++; if (lows != 1) $display("FAIL strobe_count: got %0d low clks want 1", lows); else pass_cnt++;
    total_cnt++; if (first != 5) $display("FAIL strobe_pos: got %0d want 5", first); else pass_cnt++;
  endtask

  task automatic test_latch();
    logic [WIDTH-1:0] d;
    bus_write(2, R_CTRL, 16'h0008);
    bus_write(2, R_RELOAD, 16'd10);
    tk();
    tick = 1'b1;
    tk(); tk(); tk();
    bus_write(2, R_LATCH, 16'h0);
    tk();
    bus_write(2, R_LATCH, 16'h0);
    bus_read(2, R_COUNT, d);
    total_cnt++; if (d !== 16'd4) $display("FAIL latch_live: got %0d want 4", d); else pass_cnt++;
    bus_read(2, R_CTRL, d);
    total_cnt++; if (d !== 16'h0048) $display("FAIL latch_flag: got %h want 0048", d); else pass_cnt++;
    bus_read(2, R_LATCH, d);
    total_cnt++; if (d !== 16'd7) $display("FAIL latch_snap: got %0d want 7", d); else pass_cnt++;
    tick = 1'b0;
    bus_read(2, R_CTRL, d);
    total_cnt++; if (d !== 16'h0008) $display("FAIL latch_clear: got %h want 0008", d); else pass_cnt++;
  endtask

  task automatic test_bus_edges();
    logic [WIDTH-1:0] d;
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = AW'(2 * 4 + int'(R_CTRL)); idata = 16'h0003;
    tk();
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    total_cnt++; if (odata !== 16'h0) $display("FAIL rdwr_odata: got %h want 0000", odata); else pass_cnt++;
    bus_read(2, R_CTRL, d);
    total_cnt++; if (d !== 16'h0023) $display("FAIL rdwr_write: got %h want 0023", d); else pass_cnt++;
    tk();
    total_cnt++; if (odata !== 16'h0) $display("FAIL odata_idle: got %h want 0000", odata); else pass_cnt++;
    bus_read(3, R_CTRL, d);
    total_cnt++; if (d !== 16'h0) $display("FAIL bad_channel: got %h want 0000", d); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] d;
    bus_write(0, R_CTRL, 16'h0018);
    bus_write(0, R_RELOAD, 16'd2);
    bus_write(1, R_CTRL, 16'h000A);
    bus_write(1, R_RELOAD, 16'd4);
    tick = 1'b1;
    tk(); tk(); tk(); tk();
    total_cnt++; if (irq !== 1'b1) $display("FAIL mid_irq_pre: got %b want 1", irq); else pass_cnt++;
    total_cnt++; if (out[1] !== 1'b0) $display("FAIL mid_out_pre: got %b want 0", out[1]); else pass_cnt++;
    reset_n = 1'b0;
    tk();
    total_cnt++; if (out !== 3'b111) $display("FAIL mid_out: got %b want 111", out); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL mid_irq: got %b want 0", irq); else pass_cnt++;
    reset_n = 1'b1;
    tick = 1'b0;
    bus_read(1, R_COUNT, d);
    total_cnt++; if (d !== 16'h0) $display("FAIL mid_count: got %h want 0000", d); else pass_cnt++;
    bus_read(0, R_CTRL, d);
    total_cnt++; if (d !== 16'h0020) $display("FAIL mid_ctrl: got %h want 0020", d); else pass_cnt++;
  endtask

  initial begin
    reset_n = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; tick = 1'b0;
    addr = '0; idata = '0; gate = 3'b111;
    cs8 = 1'b0; addr8 = '0; idata8 = '0; gate8 = 2'b11;
    test_reset();
    test_mode0();
    test_rate();
    test_gate();
    test_square();
    test_square_full();
    test_strobe();
    test_latch();
    test_bus_edges();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
